param_cpu: RTL
==============

PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DW, default 8: data and register width in bits; SHALL be at least 4.
REQ-002 Parameter RN, default 32: register-file depth; SHALL be at least 8 and at most 2**DW.
REQ-003 Parameter AW, default 8: program-address width.
REQ-004 Parameter GW, default 6: GPO width; SHALL be at most DW.
REQ-005 Parameter CNTMAX, default 12500000: slow-step divider terminal count.
REQ-006 Instruction width IW = 11+2*DW+AW bits, 35 at defaults.
REQ-007 Clock  in  1  single system clock; all logic on the rising edge.
REQ-008 Reset  in  1  synchronous, active-high reset.
REQ-009 Din  in  DW  signed input sample.
REQ-010 Sample  in  1  asynchronous sample strobe.
REQ-011 Turbo  in  1  asynchronous mode switch: 1 = step every clock.
REQ-012 Instr  in  IW  instruction at IP, from combinational program memory.
REQ-013 IP  out  AW  instruction pointer.
REQ-014 Dout  out  DW  contents of register RN-2.
REQ-015 Dval  out  1  one-cycle pulse marking new Dout.
REQ-016 GPO  out  GW  contents of register RN-3, bits GW-1..0.
REQ-017 Debug  out  4  {state[1:0], Z, C}.

Function
REQ-020 Field layout, MSB first, SHALL be: grp[4], cmd[3], t1[2], a1[DW], t2[2], a2[DW], addr[AW].
REQ-021 Turbo and Sample SHALL each pass through a 2-flop synchroniser before use.
REQ-022 Counter cnt SHALL count 0..CNTMAX and then wrap to 0.
REQ-023 step SHALL be asserted when (cnt==0 or synchronised Turbo) and not Reset.
REQ-024 State and register updates SHALL occur only on step cycles.
REQ-025 Special registers SHALL be: RN-1 flags {..,N,C,Z}, RN-2 Dout, RN-3 GPO, RN-4 Din.
REQ-026 Operand rule: t1=0 means the value is a1 (immediate); t1=1 means Reg[a1].
REQ-027 Destination rule: the destination is always Reg[a2]; index values of RN or above SHALL cause no write.
REQ-028 States SHALL be RUN=0, WAIT=1, HALT=2.
REQ-029 grp 0 MOV: Reg[a2] <= operand; IP+1.
REQ-030 grp 1 ACC, cmd 0..4 = ADD, SUB, AND, OR, XOR: Reg[a2] <= Reg[a2] op operand, truncated to DW bits; IP+1.
REQ-031 ACC cmd 5..7 SHALL act as NOP.
REQ-032 ACC flags SHALL update: Z = result==0; C = carry-out on ADD, borrow on SUB, 0 on logic ops; N = result MSB.
REQ-033 If an ACC destination is the flags register, the flag update SHALL win.
REQ-034 grp 2 JMP, cmd 0..3 = always, Z, C, !Z: if the condition is true, IP <= addr, else IP+1; other cmd values SHALL act as NOP.
REQ-035 grp 3 ATC: if a sample is pending, Reg[RN-4] <= Din, clear pending, IP+1; otherwise go to WAIT and hold IP.
REQ-036 WAIT: on each step, retry ATC; on success return to RUN.
REQ-037 grp 15 HALT: enter HALT, hold IP; leave HALT only on Reset.
REQ-038 All other grp values SHALL be NOP: IP+1.
REQ-039 Pending SHALL be set on a synchronised Sample rising edge and cleared when consumed.
REQ-040 Pending set and consume in the same cycle SHALL leave pending = 1.
REQ-041 Dval SHALL be 1 for exactly the Clock cycle after a step that writes Reg[RN-2], otherwise 0.
REQ-042 IP SHALL wrap from 2**AW-1 to 0.

Reset
REQ-050 Synchronous Reset SHALL clear: IP=0, all registers 0, cnt=0, pending 0, Dval 0, state RUN, synchronisers 0.
REQ-051 Reset SHALL override step and any in-progress WAIT or HALT.
REQ-052 Dout, GPO and Debug SHALL be 0 the cycle after Reset.

Verification
REQ-060 Turbo=1, MOV imm 0x7F->R30 -> Dout=0x7F, Dval high for 1 cycle, IP=1.
REQ-061 R5=0xFF, ACC ADD imm 1 into R5 -> R5=0x00, Z=1, C=1, N=0; next JMP-Z addr 0x10 -> IP=0x10.
REQ-062 ATC with no Sample -> state WAIT, IP held; Sample pulse with Din=-3 -> R28=0xFD, IP advances, state RUN.
REQ-063 Turbo=0, CNTMAX=3 -> IP advances once every 4 clocks.
REQ-064 HALT, then 10 clocks -> IP constant, Debug[3:2]=2; Reset -> IP=0, Debug=0.
REQ-065 DW=16, RN=16 build: SUB 0x0000-1 -> result 0xFFFF, C=1, N=1; write to a2=20 -> no register changes.

Source files
------------

// File: rtl/param_cpu.sv
// Small parameterised accumulator CPU: MOV/ACC/JMP/ATC/HALT over a flat register file,
// stepped by a clock divider or every clock in turbo mode.
module param_cpu #(
  parameter int unsigned DW     = 8,
  parameter int unsigned RN     = 32,
  parameter int unsigned AW     = 8,
  parameter int unsigned GW     = 6,
  parameter int unsigned CNTMAX = 12500000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic signed [DW-1:0]   Din,
  input  logic                   Sample,
  input  logic                   Turbo,
  input  logic [11+2*DW+AW-1:0]  Instr,
  output logic [AW-1:0]          IP,
  output logic [DW-1:0]          Dout,
  output logic                   Dval,
  output logic [GW-1:0]          GPO,
  output logic [3:0]             Debug
);

  localparam int unsigned IW  = 11 + 2*DW + AW;
  localparam int unsigned RIW = $clog2(RN);
  localparam int unsigned CW  = (CNTMAX < 1) ? 1 : $clog2(CNTMAX + 1);

  localparam logic [RIW-1:0] R_FLG  = RIW'(RN - 1);
  localparam logic [RIW-1:0] R_OUT  = RIW'(RN - 2);
  localparam logic [RIW-1:0] R_GPO  = RIW'(RN - 3);
  localparam logic [RIW-1:0] R_DIN  = RIW'(RN - 4);
  localparam logic [DW:0]    RN_LIM = (DW+1)'(RN);
  localparam logic [CW-1:0]  CNT_TOP = CW'(CNTMAX);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state, nxt_state;
  logic [AW-1:0]   ip_q, nxt_ip;
  logic [DW-1:0]   regs [RN];
  logic [CW-1:0]   cnt;
  logic [1:0]      turbo_q;
  logic [2:0]      sample_q;
  logic            pending;
  logic            dval_q;

  // Instruction fields, MSB first
  logic [3:0]      grp;
  logic [2:0]      cmd;
  logic [1:0]      t1;
  logic [1:0]      t2;
  logic [DW-1:0]   a1;
  logic [DW-1:0]   a2;
  logic [AW-1:0]   addr;

  assign grp  = Instr[IW-1 -: 4];
  assign cmd  = Instr[IW-5 -: 3];
  assign t1   = Instr[IW-8 -: 2];
  assign a1   = Instr[AW+DW+2 +: DW];
  assign t2   = Instr[AW+DW +: 2];
  assign a2   = Instr[AW +: DW];
  assign addr = Instr[AW-1:0];

  // Second operand type is architecturally ignored: the destination is always a register.
  logic unused_t2;
  assign unused_t2 = ^t2;

  logic            step_c;
  logic            sample_rise_c;
  logic            a1_ok_c, a2_ok_c;
  logic [DW-1:0]   operand_c, dst_val_c;
  logic            flag_z_c, flag_c_c;

  assign step_c        = ((cnt == '0) || turbo_q[1]) && !Reset;
  assign sample_rise_c = sample_q[1] & ~sample_q[2];
  assign a1_ok_c       = {1'b0, a1} < RN_LIM;
  assign a2_ok_c       = {1'b0, a2} < RN_LIM;
  assign operand_c     = (t1 == 2'd1) ? (a1_ok_c ? regs[a1[RIW-1:0]] : '0) : a1;
  assign dst_val_c     = a2_ok_c ? regs[a2[RIW-1:0]] : '0;
  assign flag_z_c      = regs[R_FLG][0];
  assign flag_c_c      = regs[R_FLG][1];

  logic            wr_en;
  logic [RIW-1:0]  wr_idx;
  logic [DW-1:0]   wr_data;
  logic            flg_en;
  logic [2:0]      flg_val;
  logic            consume;
  logic [DW:0]     alu;
  logic            take;

  // Next-state, next-IP and register-write decode
  always_comb begin
    nxt_state = state;
    nxt_ip    = ip_q + AW'(1);
    wr_en     = 1'b0;
    wr_idx    = a2[RIW-1:0];
    wr_data   = operand_c;
    flg_en    = 1'b0;
    flg_val   = 3'b000;
    consume   = 1'b0;
    alu       = '0;
    take      = 1'b0;

    case (state)
      S_HALT: begin
        nxt_ip = ip_q;
      end

      S_WAIT: begin
        if (pending) begin
          wr_en     = 1'b1;
          wr_idx    = R_DIN;
          wr_data   = $unsigned(Din);
          consume   = 1'b1;
          nxt_state = S_RUN;
        end else begin
          nxt_ip = ip_q;
        end
      end

      default: begin
        case (grp)
          4'd0: begin
            wr_en = a2_ok_c;
          end

          4'd1: begin
            case (cmd)
              3'd0: alu = {1'b0, dst_val_c} + {1'b0, operand_c};
              3'd1: alu = {1'b0, dst_val_c} - {1'b0, operand_c};
              3'd2: alu = {1'b0, dst_val_c & operand_c};
              3'd3: alu = {1'b0, dst_val_c | operand_c};
              3'd4: alu = {1'b0, dst_val_c ^ operand_c};
              default: alu = '0;
            endcase
            if (cmd <= 3'd4) begin
              wr_en   = a2_ok_c;
              wr_data = alu[DW-1:0];
              flg_en  = 1'b1;
              // Logic ops never set alu[DW], so it doubles as carry/borrow
              flg_val = {alu[DW-1], alu[DW], (alu[DW-1:0] == '0)};
            end
          end

          4'd2: begin
            case (cmd)
              3'd0:    take = 1'b1;
              3'd1:    take = flag_z_c;
              3'd2:    take = flag_c_c;
              3'd3:    take = ~flag_z_c;
              default: take = 1'b0;
            endcase
            if (take) nxt_ip = addr;
          end

          4'd3: begin
            if (pending) begin
              wr_en   = 1'b1;
              wr_idx  = R_DIN;
              wr_data = $unsigned(Din);
              consume = 1'b1;
            end else begin
              nxt_state = S_WAIT;
              nxt_ip    = ip_q;
            end
          end

          4'd15: begin
            nxt_state = S_HALT;
            nxt_ip    = ip_q;
          end

          default: ;
        endcase
      end
    endcase
  end

  // State and instruction pointer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_RUN;
      ip_q  <= '0;
    end else if (step_c) begin
      state <= nxt_state;
      ip_q  <= nxt_ip;
    end
  end

  // Synchronisers, divider, sample capture, register file and Dval
  always_ff @(posedge Clock) begin
    if (Reset) begin
      turbo_q  <= '0;
      sample_q <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      dval_q   <= 1'b0;
      regs     <= '{default: '0};
    end else begin
      turbo_q  <= {turbo_q[0], Turbo};
      sample_q <= {sample_q[1:0], Sample};
      cnt      <= (cnt == CNT_TOP) ? '0 : cnt + CW'(1);
      // A new edge wins over a same-cycle consume
      pending  <= sample_rise_c | (pending & ~(step_c & consume));
      dval_q   <= step_c & wr_en & (wr_idx == R_OUT);
      if (step_c) begin
        if (wr_en)  regs[wr_idx] <= wr_data;
        if (flg_en) regs[R_FLG][2:0] <= flg_val;
      end
    end
  end

  assign IP    = ip_q;
  assign Dout  = regs[R_OUT];
  assign Dval  = dval_q;
  assign GPO   = regs[R_GPO][GW-1:0];
  assign Debug = {state, flag_z_c, flag_c_c};

endmodule
